// File: rtl/uart_bus_master.sv
// uart_bus_master
// Serial debug bus initiator. Collects command frames from the UART receive
// byte stream, runs one read or write cycle on the CPU data bus, then sends
// the result back through the UART transmitter.
//
// Frame layout: command ('W' = 0x57 or 'R' = 0x52), 4 address bytes MSB
// first, then 4 data bytes MSB first for writes only.
// A write is answered with 'K' (0x4B). A read is answered with the 4 bytes
// of read data, MSB first.

module uart_bus_master #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy,
    output logic        frame_err,
    output logic        overrun
);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RESP_ACK  = 8'h4B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_REQ,
        ST_BUS,
        ST_RESP
    } state_t;

    // Handshake for one transmitted byte: wait until the transmitter is free,
    // pulse tx_start, skip one cycle while tx_busy has not yet risen, then
    // wait for tx_busy to fall.
    typedef enum logic [1:0] {
        TX_SEND,
        TX_HOLD,
        TX_WAIT
    } tx_phase_t;

    state_t      state_reg,       state_next;
    tx_phase_t   tx_phase_reg,    tx_phase_next;
    logic [1:0]  byte_cnt_reg,    byte_cnt_next;
    logic        is_write_reg,    is_write_next;
    logic [31:0] addr_reg,        addr_next;
    logic [31:0] wdata_reg,       wdata_next;
    logic [31:0] resp_reg,        resp_next;
    logic [31:0] timeout_cnt_reg, timeout_cnt_next;
    logic        overrun_reg,     overrun_next;

    logic        frame_active;
    logic        timeout_hit;
    logic        last_tx_byte;
    logic [7:0]  resp_byte [4];

    // Read-response byte lanes, lane 0 is the most significant byte and is
    // sent first.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_resp_lane
            assign resp_byte[gi] = resp_reg[31 - 8*gi -: 8];
        end
    endgenerate

    assign frame_active = (state_reg == ST_ADDR) || (state_reg == ST_DATA);

    // The abort fires in the cycle where the idle count would reach the
    // limit; a byte arriving in that same cycle wins and keeps the frame.
    assign timeout_hit  = frame_active && !rx_valid &&
                          ((timeout_cnt_reg + 32'd1) == TIMEOUT_CYCLES);

    assign last_tx_byte = is_write_reg || (byte_cnt_reg == 2'd3);

    assign busy    = (state_reg != ST_IDLE);
    assign addr    = addr_reg;
    assign wdata   = wdata_reg;
    assign overrun = overrun_reg;

    // State and datapath registers; reset clears everything asynchronously so
    // bus strobes and requests drop the moment reset is asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            tx_phase_reg    <= TX_SEND;
            byte_cnt_reg    <= 2'd0;
            is_write_reg    <= 1'b0;
            addr_reg        <= 32'd0;
            wdata_reg       <= 32'd0;
            resp_reg        <= 32'd0;
            timeout_cnt_reg <= 32'd0;
            overrun_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            tx_phase_reg    <= tx_phase_next;
            byte_cnt_reg    <= byte_cnt_next;
            is_write_reg    <= is_write_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
            resp_reg        <= resp_next;
            timeout_cnt_reg <= timeout_cnt_next;
            overrun_reg     <= overrun_next;
        end
    end

    // Next-state logic and all strobe outputs.
    always_comb begin
        state_next       = state_reg;
        tx_phase_next    = tx_phase_reg;
        byte_cnt_next    = byte_cnt_reg;
        is_write_next    = is_write_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;
        resp_next        = resp_reg;
        timeout_cnt_next = 32'd0;
        overrun_next     = overrun_reg;

        bus_req   = 1'b0;
        rd        = 1'b0;
        wr        = 1'b0;
        tx_start  = 1'b0;
        tx_data   = 8'h00;
        frame_err = 1'b0;

        // Inter-byte idle counter only runs while a frame is being collected.
        if (frame_active) begin
            timeout_cnt_next = rx_valid ? 32'd0 : (timeout_cnt_reg + 32'd1);
        end

        case (state_reg)
            ST_IDLE: begin
                // Unknown command bytes are dropped without any side effect.
                if (rx_valid) begin
                    if (rx_data == CMD_WRITE) begin
                        is_write_next = 1'b1;
                        byte_cnt_next = 2'd0;
                        state_next    = ST_ADDR;
                    end else if (rx_data == CMD_READ) begin
                        is_write_next = 1'b0;
                        byte_cnt_next = 2'd0;
                        state_next    = ST_ADDR;
                    end
                end
            end

            ST_ADDR: begin
                if (timeout_hit) begin
                    frame_err  = 1'b1;
                    state_next = ST_IDLE;
                end else if (rx_valid) begin
                    addr_next     = {addr_reg[23:0], rx_data};
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        state_next = is_write_reg ? ST_DATA : ST_REQ;
                    end
                end
            end

            ST_DATA: begin
                if (timeout_hit) begin
                    frame_err  = 1'b1;
                    state_next = ST_IDLE;
                end else if (rx_valid) begin
                    wdata_next    = {wdata_reg[23:0], rx_data};
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        state_next = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                // Grant wait is unbounded; the arbiter guarantees progress.
                bus_req = 1'b1;
                if (bus_gnt) begin
                    state_next = ST_BUS;
                end
            end

            ST_BUS: begin
                bus_req = 1'b1;
                wr      = is_write_reg;
                rd      = !is_write_reg;
                if (!is_write_reg) begin
                    resp_next = rdata;
                end
                byte_cnt_next = 2'd0;
                tx_phase_next = TX_SEND;
                state_next    = ST_RESP;
            end

            ST_RESP: begin
                tx_data = is_write_reg ? RESP_ACK : resp_byte[byte_cnt_reg];
                case (tx_phase_reg)
                    TX_SEND: begin
                        if (!tx_busy) begin
                            tx_start      = 1'b1;
                            tx_phase_next = TX_HOLD;
                        end
                    end
                    TX_HOLD: begin
                        tx_phase_next = TX_WAIT;
                    end
                    TX_WAIT: begin
                        if (!tx_busy) begin
                            tx_phase_next = TX_SEND;
                            if (last_tx_byte) begin
                                byte_cnt_next = 2'd0;
                                state_next    = ST_IDLE;
                            end else begin
                                byte_cnt_next = byte_cnt_reg + 2'd1;
                            end
                        end
                    end
                    default: begin
                        tx_phase_next = TX_SEND;
                    end
                endcase
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Bytes arriving while a command is in flight cannot be buffered.
        if (rx_valid && ((state_reg == ST_REQ) || (state_reg == ST_BUS) ||
                         (state_reg == ST_RESP))) begin
            overrun_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Testbench for uart_bus_master: drives UART command frames, models the bus
// responder and UART transmitter, and scores bus cycles and transmitted
// bytes against queues of expected results.
`timescale 1ns/1ps

module tb_uart_bus_master;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        bus_req;
    logic        bus_gnt;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        frame_err;
    logic        overrun;

    logic [31:0] rdata_val;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_txn_t;

    bus_txn_t    bus_q [$];
    logic [7:0]  tx_q  [$];

    int check_count = 0;
    int pass_count  = 0;

    uart_bus_master #(
        .TIMEOUT_CYCLES(32'd16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .rd        (rd),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    // Responder drives read data only while the read strobe is high.
    assign rdata = rd ? rdata_val : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            pass_count++;
        end
    endtask

    // Caller sits on a falling edge; the byte is sampled at the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d);
        send_byte(8'h57);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
    endtask

    task automatic send_read(input logic [31:0] a);
        send_byte(8'h52);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        bus_txn_t t;
        t.is_wr = 1'b1;
        t.addr  = a;
        t.wdata = d;
        bus_q.push_back(t);
        tx_q.push_back(8'h4B);
    endtask

    task automatic expect_read(input logic [31:0] a, input logic [31:0] d);
        bus_txn_t t;
        t.is_wr = 1'b0;
        t.addr  = a;
        t.wdata = 32'h0;
        bus_q.push_back(t);
        for (int i = 3; i >= 0; i--) tx_q.push_back(d[8*i +: 8]);
    endtask

    // Bounded wait for the DUT to return to IDLE; ends 1 ns after a falling edge.
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            #1;
            if (!busy) break;
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_bus_q"}, 32'(bus_q.size()), 32'd0);
        check({tag, "_tx_q"},  32'(tx_q.size()),  32'd0);
    endtask

    // Bus monitor: every strobe must match the oldest expected bus cycle.
    initial begin
        bus_txn_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rd || wr) begin
                $display("bus   %s addr=%h wdata=%h", wr ? "wr" : "rd", addr, wdata);
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", 32'(bus_q.size()), 32'd1);
                end else begin
                    e = bus_q.pop_front();
                    check("bus_kind", 32'({rd, wr}), 32'({~e.is_wr, e.is_wr}));
                    check("bus_addr", addr, e.addr);
                    if (e.is_wr) check("bus_wdata", wdata, e.wdata);
                end
            end
        end
    end

    // Transmit monitor: every tx_start must carry the next expected byte.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            #1;
            if (tx_start) begin
                $display("tx    byte=%h", tx_data);
                if (tx_q.size() == 0) begin
                    check("tx_unexpected", 32'(tx_q.size()), 32'd1);
                end else begin
                    b = tx_q.pop_front();
                    check("tx_byte", 32'(tx_data), 32'(b));
                end
            end
        end
    end

    // UART transmitter model: busy rises the cycle after tx_start, holds 4 cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (tx_start) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (4) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        int pulses;

        reset     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        bus_gnt   = 1'b1;
        rdata_val = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_bus_req",  32'(bus_req),  32'd0);
        check("rst_rdwr",     32'({rd, wr}), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data",  32'(tx_data),  32'd0);
        check("rst_overrun",  32'(overrun),  32'd0);
        check("rst_addr",     addr,          32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Write frame; bus_req must follow the last byte by one cycle
        @(negedge clk);
        expect_write(32'h4000000C, 32'h000000A5);
        send_write(32'h4000000C, 32'h000000A5);
        #1;
        check("wr_req_latency", 32'(bus_req), 32'd1);
        wait_idle("wr_idle");
        check_drained("wr");

        // Read frame
        @(negedge clk);
        rdata_val = 32'h12345678;
        expect_read(32'h40000000, 32'h12345678);
        send_read(32'h40000000);
        wait_idle("rd_idle");
        check_drained("rd");

        // Grant held off for 20 cycles
        @(negedge clk);
        bus_gnt = 1'b0;
        expect_write(32'h40000004, 32'h00000001);
        send_write(32'h40000004, 32'h00000001);
        for (int i = 0; i < 20; i++) begin
            #1;
            check("gnt_wait_req",  32'(bus_req),  32'd1);
            check("gnt_wait_rdwr", 32'({rd, wr}), 32'd0);
            @(negedge clk);
        end
        bus_gnt = 1'b1;
        #1;
        check("gnt_cycle_m_wr", 32'(wr), 32'd0);
        @(negedge clk);
        #1;
        check("gnt_m1_wr", 32'(wr), 32'd1);
        @(negedge clk);
        #1;
        check("gnt_m2_req", 32'(bus_req), 32'd0);
        check("gnt_m2_wr",  32'(wr),      32'd0);
        wait_idle("gnt_idle");
        check_drained("gnt");

        // Junk command byte in IDLE
        @(negedge clk);
        send_byte(8'hFF);
        #1;
        check("junk_busy",    32'(busy),    32'd0);
        check("junk_overrun", 32'(overrun), 32'd0);

        // Timeout: frame_err exactly at cycle 16 after the last byte
        @(negedge clk);
        send_byte(8'h57);
        send_byte(8'h40);
        send_byte(8'h00);
        seen   = -1;
        pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            #1;
            if (frame_err) begin
                pulses++;
                if (seen < 0) seen = k;
            end
            @(negedge clk);
        end
        check("to_cycle",  32'(seen),   32'd16);
        check("to_pulses", 32'(pulses), 32'd1);
        check("to_busy",   32'(busy),   32'd0);
        check_drained("to");

        // Byte arriving exactly at the terminal count keeps the frame alive
        expect_write(32'h40000018, 32'h00000077);
        send_byte(8'h57);
        repeat (15) @(negedge clk);
        rx_data  = 8'h40;
        rx_valid = 1'b1;
        #1;
        check("coinc_no_abort", 32'(frame_err), 32'd0);
        @(negedge clk);
        rx_valid = 1'b0;
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h18);
        for (int i = 3; i >= 0; i--) send_byte(8'(32'h77 >> (8*i)));
        wait_idle("coinc_idle");
        check_drained("coinc");

        // Byte during RESP of a read sets overrun; response unaffected
        @(negedge clk);
        rdata_val = 32'hCAFEF00D;
        expect_read(32'h40000008, 32'hCAFEF00D);
        send_read(32'h40000008);
        for (int n = 0; n < 50; n++) begin
            #1;
            if (tx_start) break;
            @(negedge clk);
        end
        @(negedge clk);
        check("ovr_before", 32'(overrun), 32'd0);
        send_byte(8'h33);
        #1;
        check("ovr_set", 32'(overrun), 32'd1);
        wait_idle("ovr_idle");
        check_drained("ovr");

        // Reset asserted while wr is high
        @(negedge clk);
        bus_gnt = 1'b0;
        begin
            bus_txn_t t;
            t.is_wr = 1'b1;
            t.addr  = 32'h40000014;
            t.wdata = 32'h00000055;
            bus_q.push_back(t);
        end
        send_write(32'h40000014, 32'h00000055);
        bus_gnt = 1'b1;
        @(negedge clk);
        #2;
        check("rstbus_wr_high", 32'(wr), 32'd1);
        reset = 1'b0;
        #1;
        check("rstbus_wr",      32'(wr),      32'd0);
        check("rstbus_bus_req", 32'(bus_req), 32'd0);
        check("rstbus_busy",    32'(busy),    32'd0);
        check("rstbus_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        expect_write(32'h40000010, 32'hDEADBEEF);
        send_write(32'h40000010, 32'hDEADBEEF);
        wait_idle("post_rst_idle");
        repeat (5) @(negedge clk);
        #1;
        check_drained("post_rst");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
